// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the MIPS32 pipeline
package pipeline_pkg;

    localparam int DEFAULT_XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'h0,
        ALU_SUB    = 4'h1,
        ALU_AND    = 4'h2,
        ALU_OR     = 4'h3,
        ALU_XOR    = 4'h4,
        ALU_NOR    = 4'h5,
        ALU_SLT    = 4'h6,
        ALU_SLTU   = 4'h7,
        ALU_SLL    = 4'h8,
        ALU_SRL    = 4'h9,
        ALU_SRA    = 4'hA,
        ALU_LUI    = 4'hB,
        ALU_MUL    = 4'hC,
        ALU_PASS_B = 4'hD
    } alu_op_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF    = 2'b00;
    localparam fwd_sel_t FWD_MEMWB = 2'b01;
    localparam fwd_sel_t FWD_EXMEM = 2'b10;

    typedef enum logic {
        EX_IDLE     = 1'b0,
        EX_MUL_BUSY = 1'b1
    } ex_state_t;

endpackage

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - iterative shift-add multiplier, one partial product per clock
module mul_iter
    import pipeline_pkg::*;
#(
    parameter int XLEN       = DEFAULT_XLEN,
    parameter int MUL_CYCLES = DEFAULT_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            hold,
    input  logic            abort,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYCLES - 1);

    logic             running;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  mcand;
    logic [XLEN-1:0]  mplier;
    logic [XLEN-1:0]  acc;
    logic [XLEN-1:0]  acc_next;

    // product already includes the current step, so it is complete on the edge where done is high
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign product  = acc_next;
    assign done     = running & (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            count   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
        end else if (abort) begin
            running <= 1'b0;
            count   <= '0;
        end else if (start) begin
            running <= 1'b1;
            count   <= '0;
            mcand   <= a;
            mplier  <= b;
            acc     <= '0;
        end else if (running && !hold) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS32 execute stage: operand forwarding, ALU, iterative multiply, EX/MEM register
module ex_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN       = DEFAULT_XLEN,
    parameter int MUL_CYCLES = DEFAULT_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            idex_valid,
    input  logic [XLEN-1:0] idex_rs1_data,
    input  logic [XLEN-1:0] idex_rs2_data,
    input  logic [XLEN-1:0] idex_imm,
    input  logic            idex_alu_src,
    input  logic [3:0]      idex_alu_op,
    input  logic [4:0]      idex_rd,
    input  logic            idex_reg_write,
    input  logic            idex_mem_read,
    input  logic            idex_mem_write,
    input  logic [1:0]      forward_a,
    input  logic [1:0]      forward_b,
    input  logic [XLEN-1:0] memwb_wb_data,
    input  logic            stall_in,
    input  logic            flush,
    output logic            exmem_valid,
    output logic            exmem_reg_write,
    output logic            exmem_mem_read,
    output logic            exmem_mem_write,
    output logic [XLEN-1:0] exmem_alu_result,
    output logic [XLEN-1:0] exmem_store_data,
    output logic [4:0]      exmem_rd,
    output logic            ex_busy
);

    localparam int SH_W = $clog2(XLEN);

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic [4:0]      rd;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] store_data;
    } exmem_t;

    ex_state_t       state;
    exmem_t          exmem_q;
    exmem_t          mul_ctrl;
    exmem_t          ex_res;
    exmem_t          mul_res;
    alu_op_t         alu_op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] mul_product;
    logic [SH_W-1:0] shamt;
    logic            is_mul;
    logic            mul_start;
    logic            mul_done;

    function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0]      sel,
                                                input logic [XLEN-1:0] rf,
                                                input logic [XLEN-1:0] exmem,
                                                input logic [XLEN-1:0] memwb);
        case (sel)
            FWD_EXMEM: return exmem;
            FWD_MEMWB: return memwb;
            default:   return rf;
        endcase
    endfunction

    assign alu_op = alu_op_t'(idex_alu_op);
    assign op_a   = fwd_mux(forward_a, idex_rs1_data, exmem_q.alu_result, memwb_wb_data);
    assign fwd_b  = fwd_mux(forward_b, idex_rs2_data, exmem_q.alu_result, memwb_wb_data);
    assign op_b   = idex_alu_src ? idex_imm : fwd_b;
    assign shamt  = op_b[SH_W-1:0];

    always_comb begin
        alu_out = '0;
        case (alu_op)
            ALU_ADD:    alu_out = op_a + op_b;
            ALU_SUB:    alu_out = op_a - op_b;
            ALU_AND:    alu_out = op_a & op_b;
            ALU_OR:     alu_out = op_a | op_b;
            ALU_XOR:    alu_out = op_a ^ op_b;
            ALU_NOR:    alu_out = ~(op_a | op_b);
            ALU_SLT:    alu_out = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU:   alu_out = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_SLL:    alu_out = op_a << shamt;
            ALU_SRL:    alu_out = op_a >> shamt;
            ALU_SRA:    alu_out = $signed(op_a) >>> shamt;
            ALU_LUI:    alu_out = op_b << 16;
            ALU_PASS_B: alu_out = op_b;
            default:    alu_out = '0;
        endcase
    end

    always_comb begin
        ex_res = '0;
        if (idex_valid) begin
            ex_res.valid      = 1'b1;
            ex_res.reg_write  = idex_reg_write;
            ex_res.mem_read   = idex_mem_read;
            ex_res.mem_write  = idex_mem_write;
            ex_res.rd         = idex_rd;
            ex_res.alu_result = alu_out;
            ex_res.store_data = fwd_b;
        end
        mul_res            = mul_ctrl;
        mul_res.alu_result = mul_product;
    end

    assign is_mul    = idex_valid & (alu_op == ALU_MUL);
    assign mul_start = (state == EX_IDLE) & is_mul & ~stall_in & ~flush;

    mul_iter #(
        .XLEN       (XLEN),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .hold    (stall_in),
        .abort   (flush),
        .a       (op_a),
        .b       (op_b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Controls of a multiply are parked in mul_ctrl at start; EX/MEM shows bubbles until the product lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EX_IDLE;
            exmem_q  <= '0;
            mul_ctrl <= '0;
        end else if (flush) begin
            state   <= EX_IDLE;
            exmem_q <= '0;
        end else if (!stall_in) begin
            case (state)
                EX_IDLE: begin
                    if (is_mul) begin
                        state    <= EX_MUL_BUSY;
                        mul_ctrl <= ex_res;
                        exmem_q  <= '0;
                    end else begin
                        exmem_q <= ex_res;
                    end
                end
                EX_MUL_BUSY: begin
                    if (mul_done) begin
                        state   <= EX_IDLE;
                        exmem_q <= mul_res;
                    end else begin
                        exmem_q <= '0;
                    end
                end
                default: state <= EX_IDLE;
            endcase
        end
    end

    assign ex_busy = ~rst & (stall_in
                           | ((state == EX_IDLE) & is_mul)
                           | ((state == EX_MUL_BUSY) & ~mul_done));

    assign exmem_valid      = exmem_q.valid;
    assign exmem_reg_write  = exmem_q.reg_write;
    assign exmem_mem_read   = exmem_q.mem_read;
    assign exmem_mem_write  = exmem_q.mem_write;
    assign exmem_rd         = exmem_q.rd;
    assign exmem_alu_result = exmem_q.alu_result;
    assign exmem_store_data = exmem_q.store_data;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed self-checking bench for ex_stage
module tb_ex_stage;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        idex_valid = 1'b0;
    logic [31:0] idex_rs1_data = '0;
    logic [31:0] idex_rs2_data = '0;
    logic [31:0] idex_imm = '0;
    logic        idex_alu_src = 1'b0;
    logic [3:0]  idex_alu_op = '0;
    logic [4:0]  idex_rd = '0;
    logic        idex_reg_write = 1'b0;
    logic        idex_mem_read = 1'b0;
    logic        idex_mem_write = 1'b0;
    logic [1:0]  forward_a = '0;
    logic [1:0]  forward_b = '0;
    logic [31:0] memwb_wb_data = '0;
    logic        stall_in = 1'b0;
    logic        flush = 1'b0;
    logic        exmem_valid;
    logic        exmem_reg_write;
    logic        exmem_mem_read;
    logic        exmem_mem_write;
    logic [31:0] exmem_alu_result;
    logic [31:0] exmem_store_data;
    logic [4:0]  exmem_rd;
    logic        ex_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk              (clk),
        .rst              (rst),
        .idex_valid       (idex_valid),
        .idex_rs1_data    (idex_rs1_data),
        .idex_rs2_data    (idex_rs2_data),
        .idex_imm         (idex_imm),
        .idex_alu_src     (idex_alu_src),
        .idex_alu_op      (idex_alu_op),
        .idex_rd          (idex_rd),
        .idex_reg_write   (idex_reg_write),
        .idex_mem_read    (idex_mem_read),
        .idex_mem_write   (idex_mem_write),
        .forward_a        (forward_a),
        .forward_b        (forward_b),
        .memwb_wb_data    (memwb_wb_data),
        .stall_in         (stall_in),
        .flush            (flush),
        .exmem_valid      (exmem_valid),
        .exmem_reg_write  (exmem_reg_write),
        .exmem_mem_read   (exmem_mem_read),
        .exmem_mem_write  (exmem_mem_write),
        .exmem_alu_result (exmem_alu_result),
        .exmem_store_data (exmem_store_data),
        .exmem_rd         (exmem_rd),
        .ex_busy          (ex_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src, input logic [1:0] fa,
                         input logic [1:0] fb, input logic [4:0] rd);
        idex_valid     = 1'b1;
        idex_alu_op    = op;
        idex_rs1_data  = a;
        idex_rs2_data  = b;
        idex_imm       = imm;
        idex_alu_src   = src;
        forward_a      = fa;
        forward_b      = fb;
        idex_rd        = rd;
        idex_reg_write = 1'b1;
        idex_mem_read  = 1'b0;
        idex_mem_write = 1'b0;
    endtask

    // Runs one multiply as the upstream would: hold ID/EX while busy, advance once busy drops
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int stall_from,
                           input int stall_len, input int flush_at, output int busy_cycles,
                           output int first_low, output int valid_edge, output logic [31:0] result);
        logic adv;
        busy_cycles = 0;
        first_low   = -1;
        valid_edge  = -1;
        result      = '0;
        drive(ALU_MUL, a, b, 32'h0, 1'b0, FWD_RF, FWD_RF, 5'd9);
        for (int c = 0; c < 80; c++) begin
            stall_in = (c >= stall_from) && (c < stall_from + stall_len);
            flush    = (c == flush_at);
            if (c == flush_at) idex_valid = 1'b0;
            if (c == 5) begin
                idex_rs1_data = 32'h5555_5555;
                idex_rs2_data = 32'h0000_0007;
                memwb_wb_data = 32'h9999_9999;
                forward_a     = FWD_MEMWB;
            end
            #1;
            if (ex_busy) busy_cycles++;
            else if (first_low < 0) first_low = c;
            adv = !ex_busy;
            step();
            if (exmem_valid && valid_edge < 0) begin
                valid_edge = c;
                result     = exmem_alu_result;
            end
            if (adv) break;
        end
        stall_in   = 1'b0;
        flush      = 1'b0;
        idex_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (exmem_valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b want 0", exmem_valid); end
        checks++; if (exmem_reg_write !== 1'b0) begin errors++; $display("FAIL reset reg_write: got %b want 0", exmem_reg_write); end
        checks++; if (exmem_mem_read !== 1'b0) begin errors++; $display("FAIL reset mem_read: got %b want 0", exmem_mem_read); end
        checks++; if (exmem_mem_write !== 1'b0) begin errors++; $display("FAIL reset mem_write: got %b want 0", exmem_mem_write); end
        checks++; if (exmem_alu_result !== 32'h0) begin errors++; $display("FAIL reset alu_result: got %h want 0", exmem_alu_result); end
        checks++; if (exmem_store_data !== 32'h0) begin errors++; $display("FAIL reset store_data: got %h want 0", exmem_store_data); end
        checks++; if (exmem_rd !== 5'd0) begin errors++; $display("FAIL reset rd: got %0d want 0", exmem_rd); end
        checks++; if (ex_busy !== 1'b0) begin errors++; $display("FAIL reset ex_busy: got %b want 0", ex_busy); end
    endtask

    task automatic test_forward();
        drive(ALU_ADD, 32'h10, 32'h0, 32'h0, 1'b0, FWD_RF, FWD_RF, 5'd1);
        step();
        checks++; if (exmem_alu_result !== 32'h10) begin errors++; $display("FAIL fwd seed: got %h want 10", exmem_alu_result); end
        memwb_wb_data = 32'h20;
        drive(ALU_ADD, 32'h5, 32'h0, 32'h1, 1'b1, FWD_EXMEM, FWD_RF, 5'd2);
        step();
        checks++; if (exmem_alu_result !== 32'h11) begin errors++; $display("FAIL fwd_a exmem: got %h want 11", exmem_alu_result); end
        checks++; if (exmem_rd !== 5'd2 || exmem_valid !== 1'b1) begin errors++; $display("FAIL fwd_a rd/valid: got %0d/%b want 2/1", exmem_rd, exmem_valid); end
        drive(ALU_ADD, 32'h5, 32'h0, 32'h1, 1'b1, FWD_MEMWB, FWD_RF, 5'd3);
        step();
        checks++; if (exmem_alu_result !== 32'h21) begin errors++; $display("FAIL fwd_a memwb: got %h want 21", exmem_alu_result); end
        drive(ALU_ADD, 32'h5, 32'h0, 32'h1, 1'b1, 2'b11, FWD_RF, 5'd4);
        step();
        checks++; if (exmem_alu_result !== 32'h6) begin errors++; $display("FAIL fwd_a 11: got %h want 6", exmem_alu_result); end
        drive(ALU_ADD, 32'h5, 32'h7, 32'h0, 1'b1, FWD_RF, FWD_EXMEM, 5'd5);
        idex_mem_write = 1'b1;
        idex_reg_write = 1'b0;
        step();
        checks++; if (exmem_alu_result !== 32'h5 || exmem_store_data !== 32'h6) begin errors++; $display("FAIL fwd_b exmem store: got %h/%h want 5/6", exmem_alu_result, exmem_store_data); end
        checks++; if (exmem_mem_write !== 1'b1 || exmem_reg_write !== 1'b0) begin errors++; $display("FAIL store ctrl: got mw=%b rw=%b want 1/0", exmem_mem_write, exmem_reg_write); end
        drive(ALU_ADD, 32'h1, 32'h7, 32'h0, 1'b0, FWD_RF, FWD_MEMWB, 5'd6);
        step();
        checks++; if (exmem_alu_result !== 32'h21 || exmem_store_data !== 32'h20) begin errors++; $display("FAIL fwd_b memwb: got %h/%h want 21/20", exmem_alu_result, exmem_store_data); end
        drive(ALU_ADD, 32'h1, 32'h7, 32'h0, 1'b0, FWD_RF, 2'b11, 5'd7);
        step();
        checks++; if (exmem_alu_result !== 32'h8 || exmem_store_data !== 32'h7) begin errors++; $display("FAIL fwd_b 11: got %h/%h want 8/7", exmem_alu_result, exmem_store_data); end
    endtask

    task automatic test_alu();
        logic [3:0]  ops [13];
        logic [31:0] av [13];
        logic [31:0] bv [13];
        logic [31:0] ev [13];
        ops = '{ALU_SLT, ALU_SLTU, ALU_SRA, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
                ALU_NOR, ALU_SLL, ALU_SRL, ALU_LUI, ALU_PASS_B, ALU_ADD};
        av  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h3, 32'hF0F0, 32'hF0F0, 32'hF0F0,
                32'hF0F0, 32'h1, 32'h8000_0000, 32'h0, 32'h0, 32'hFFFF_FFFF};
        bv  = '{32'h1, 32'h1, 32'h4, 32'h5, 32'hFF00, 32'hFF00, 32'hFF00,
                32'hFF00, 32'd31, 32'd31, 32'h1234, 32'hABCD, 32'h2};
        ev  = '{32'h1, 32'h0, 32'hF800_0000, 32'hFFFF_FFFE, 32'hF000, 32'hFFF0, 32'h0FF0,
                32'hFFFF_000F, 32'h8000_0000, 32'h1, 32'h1234_0000, 32'hABCD, 32'h1};
        for (int i = 0; i < 13; i++) begin
            drive(ops[i], av[i], bv[i], 32'h0, 1'b0, FWD_RF, FWD_RF, 5'(i + 1));
            step();
            checks++;
            if (exmem_alu_result !== ev[i] || exmem_valid !== 1'b1) begin
                errors++;
                $display("FAIL alu[%0d] op=%h: got %h valid=%b want %h valid=1", i, ops[i], exmem_alu_result, exmem_valid, ev[i]);
            end
        end
        idex_valid = 1'b0;
        step();
        checks++; if (exmem_valid !== 1'b0 || exmem_alu_result !== 32'h0) begin errors++; $display("FAIL idle bubble: got valid=%b res=%h want 0/0", exmem_valid, exmem_alu_result); end
    endtask

    task automatic test_mul();
        int          busy_cycles, first_low, valid_edge;
        logic [31:0] res;
        run_mul(32'h1234_5678, 32'h10, 1000, 0, -1, busy_cycles, first_low, valid_edge, res);
        checks++; if (busy_cycles !== 32) begin errors++; $display("FAIL mul busy cycles: got %0d want 32", busy_cycles); end
        checks++; if (first_low !== 32) begin errors++; $display("FAIL mul busy low cycle: got %0d want 32", first_low); end
        checks++; if (valid_edge !== 32) begin errors++; $display("FAIL mul result edge: got %0d want 32", valid_edge); end
        checks++; if (res !== 32'h2345_6780) begin errors++; $display("FAIL mul product: got %h want 23456780", res); end
        checks++; if (exmem_rd !== 5'd9 || exmem_reg_write !== 1'b1) begin errors++; $display("FAIL mul ctrl: got rd=%0d rw=%b want 9/1", exmem_rd, exmem_reg_write); end
        drive(ALU_ADD, 32'h1, 32'h2, 32'h0, 1'b0, FWD_RF, FWD_RF, 5'd3);
        step();
        checks++; if (exmem_alu_result !== 32'h3 || exmem_valid !== 1'b1) begin errors++; $display("FAIL after mul: got %h valid=%b want 3/1", exmem_alu_result, exmem_valid); end
        idex_valid = 1'b0;
    endtask

    task automatic test_stall_mul();
        int          busy_cycles, first_low, valid_edge;
        logic [31:0] res;
        run_mul(32'h1000_0001, 32'h3, 10, 3, -1, busy_cycles, first_low, valid_edge, res);
        checks++; if (busy_cycles !== 35) begin errors++; $display("FAIL stall mul busy cycles: got %0d want 35", busy_cycles); end
        checks++; if (valid_edge !== 35) begin errors++; $display("FAIL stall mul result edge: got %0d want 35", valid_edge); end
        checks++; if (res !== 32'h3000_0003) begin errors++; $display("FAIL stall mul product: got %h want 30000003", res); end
    endtask

    task automatic test_stall_single();
        drive(ALU_ADD, 32'h2, 32'h3, 32'h0, 1'b0, FWD_RF, FWD_RF, 5'd4);
        step();
        checks++; if (exmem_alu_result !== 32'h5) begin errors++; $display("FAIL stall seed: got %h want 5", exmem_alu_result); end
        drive(ALU_SUB, 32'h9, 32'h1, 32'h0, 1'b0, FWD_RF, FWD_RF, 5'd6);
        stall_in = 1'b1;
        #1;
        checks++; if (ex_busy !== 1'b1) begin errors++; $display("FAIL stall busy: got %b want 1", ex_busy); end
        step();
        step();
        checks++; if (exmem_alu_result !== 32'h5 || exmem_rd !== 5'd4 || exmem_valid !== 1'b1) begin errors++; $display("FAIL stall hold: got %h rd=%0d valid=%b want 5 rd=4 valid=1", exmem_alu_result, exmem_rd, exmem_valid); end
        stall_in = 1'b0;
        step();
        checks++; if (exmem_alu_result !== 32'h8 || exmem_rd !== 5'd6) begin errors++; $display("FAIL stall release: got %h rd=%0d want 8 rd=6", exmem_alu_result, exmem_rd); end
        idex_valid = 1'b0;
    endtask

    task automatic test_flush();
        int          busy_cycles, first_low, valid_edge, seen;
        logic [31:0] res;
        run_mul(32'h1234_5678, 32'h10, 10, 1, 10, busy_cycles, first_low, valid_edge, res);
        checks++; if (first_low !== 11) begin errors++; $display("FAIL flush busy low: got %0d want 11", first_low); end
        checks++; if (valid_edge !== -1) begin errors++; $display("FAIL flush wrote result at edge %0d want none", valid_edge); end
        checks++; if (exmem_valid !== 1'b0 || exmem_alu_result !== 32'h0) begin errors++; $display("FAIL flush bubble: got valid=%b res=%h want 0/0", exmem_valid, exmem_alu_result); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (exmem_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush late result: got %0d valid cycles want 0", seen); end
        run_mul(32'h3, 32'h5, 1000, 0, -1, busy_cycles, first_low, valid_edge, res);
        checks++; if (valid_edge !== 32 || res !== 32'd15) begin errors++; $display("FAIL mul after flush: got edge=%0d res=%h want 32/f", valid_edge, res); end
        drive(ALU_ADD, 32'h1, 32'h1, 32'h0, 1'b0, FWD_RF, FWD_RF, 5'd2);
        flush = 1'b1;
        step();
        flush      = 1'b0;
        idex_valid = 1'b0;
        checks++; if (exmem_valid !== 1'b0 || exmem_alu_result !== 32'h0) begin errors++; $display("FAIL flush single: got valid=%b res=%h want 0/0", exmem_valid, exmem_alu_result); end
    endtask

    task automatic test_reset_mid();
        int seen;
        drive(ALU_ADD, 32'h4, 32'h4, 32'h0, 1'b0, FWD_RF, FWD_RF, 5'd3);
        step();
        checks++; if (exmem_alu_result !== 32'h8) begin errors++; $display("FAIL rst seed: got %h want 8", exmem_alu_result); end
        #2 rst = 1'b1;
        #1;
        checks++; if (exmem_alu_result !== 32'h0 || exmem_valid !== 1'b0 || exmem_rd !== 5'd0) begin errors++; $display("FAIL async rst: got res=%h valid=%b rd=%0d want 0", exmem_alu_result, exmem_valid, exmem_rd); end
        step();
        rst = 1'b0;
        drive(ALU_MUL, 32'h7, 32'h6, 32'h0, 1'b0, FWD_RF, FWD_RF, 5'd8);
        repeat (6) step();
        #2 rst = 1'b1;
        #1;
        checks++; if (ex_busy !== 1'b0) begin errors++; $display("FAIL rst busy: got %b want 0", ex_busy); end
        step();
        idex_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (ex_busy !== 1'b0) begin errors++; $display("FAIL rst release busy: got %b want 0", ex_busy); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (exmem_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst partial result: got %0d valid cycles want 0", seen); end
        drive(ALU_ADD, 32'h1, 32'h1, 32'h0, 1'b0, FWD_RF, FWD_RF, 5'd1);
        step();
        checks++; if (exmem_alu_result !== 32'h2 || exmem_valid !== 1'b1) begin errors++; $display("FAIL after rst: got %h valid=%b want 2/1", exmem_alu_result, exmem_valid); end
        idex_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_alu();
        test_mul();
        test_stall_mul();
        test_stall_single();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
